// File: rtl/isa_capture_queue_if.sv
// Bus bundle for isa_capture_queue: CPU write-capture side plus transmitter/status side.
// drop_cnt is present only when CAP_DROP_CNT_EN is defined.
interface isa_capture_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cap_en;
    logic [BE_W-1:0]   cap_be;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              tx_ready;
    logic              ovf_clr;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              ovf_sticky;
`ifdef CAP_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    modport master (
        output cap_en, cap_be, cap_addr, cap_data, tx_ready, ovf_clr,
        input  out_addr, out_data, out_valid, fifo_full, fifo_empty, fifo_count, ovf_sticky
`ifdef CAP_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  cap_en, cap_be, cap_addr, cap_data, tx_ready, ovf_clr,
        output out_addr, out_data, out_valid, fifo_full, fifo_empty, fifo_count, ovf_sticky
`ifdef CAP_DROP_CNT_EN
        , output drop_cnt
`endif
    );
endinterface

// File: rtl/isa_capture_queue.sv
// Capture queue for CPU bus writes: input stage, byte-enable qualification, FIFO, paced output.
// Define CAP_DROP_CNT_EN to add the saturating drop_cnt output.
module isa_capture_queue #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 16,
    parameter int                HOLD_CYC       = 3,
    parameter logic [ADDR_W-1:0] SLOW_ADDR0     = ADDR_W'(32'h4000_1000),
    parameter logic [ADDR_W-1:0] SLOW_BASE      = ADDR_W'(32'h4000_4000),
    parameter logic [ADDR_W-1:0] SLOW_MASK      = ADDR_W'(32'hFFFF_F000),
    parameter bit                FULL_WORD_ONLY = 1'b1
) (
    input logic                clk,
    input logic                rstn,
    isa_capture_queue_if.slave bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic              stg_valid;
    logic [BE_W-1:0]   stg_be;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_data;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [HOLD_W-1:0] hold_cnt;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              ovf_q;

    logic qualified;
    logic full;
    logic empty;
    logic push;
    logic drop;
    logic pop;

    function automatic logic is_slow(input logic [ADDR_W-1:0] a);
        return (a == SLOW_ADDR0) || ((a & SLOW_MASK) == SLOW_BASE);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stg_valid <= 1'b0;
            stg_be    <= '0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else begin
            stg_valid <= bus.cap_en;
            stg_be    <= bus.cap_be;
            stg_addr  <= bus.cap_addr;
            stg_data  <= bus.cap_data;
        end
    end

    // Full is judged before any same-cycle pop, so a pop never rescues a write arriving at a full queue.
    assign qualified = stg_valid && (FULL_WORD_ONLY ? (&stg_be) : (|stg_be));
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push      = qualified && !full;
    assign drop      = qualified && full;
    assign pop       = !empty && bus.tx_ready && (hold_cnt == '0) &&
                       !(out_valid_q && is_slow(out_addr_q));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= stg_addr;
            mem_data[wr_ptr] <= stg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The hold counter loads on the same edge that presents a slow beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            hold_cnt    <= '0;
        end else begin
            out_valid_q <= pop;
            if (pop) begin
                out_addr_q <= mem_addr[rd_ptr];
                out_data_q <= mem_data[rd_ptr];
            end
            if (pop && is_slow(mem_addr[rd_ptr])) begin
                hold_cnt <= HOLD_W'(HOLD_CYC - 1);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef CAP_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
        end else if (bus.ovf_clr) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.ovf_sticky = ovf_q;
endmodule
